// File: rtl/result_writeback.sv
// Result writeback stage: buffers rows of lane results in a small show-ahead FIFO
// and writes each row as one wide word to result memory B at sequential addresses.
module result_writeback #(
    parameter int LANES     = 8,
    parameter int LANE_W    = 16,
    parameter int DEPTH     = 4,
    parameter int ADDR_STEP = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [31:0]             base_addr,
    input  logic [15:0]             row_count,
    input  logic                    res_valid,
    output logic                    res_ready,
    input  logic [LANES*LANE_W-1:0] res_data,
    output logic                    wr_en,
    input  logic                    wr_ready,
    output logic [31:0]             wr_addr,
    output logic [LANES*LANE_W-1:0] wr_data,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int ROW_W = LANES * LANE_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state;
    logic [31:0]        base_q;
    logic [15:0]        rows_q;
    logic [15:0]        acc_cnt;
    logic [15:0]        wr_cnt;

    logic [ROW_W-1:0]   fifo_mem [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   fifo_count;

    logic               fifo_empty;
    logic               push;
    logic               pop;

    // Accept side: no bypass, a full FIFO stalls upstream even if a pop is pending.
    assign fifo_empty = (fifo_count == '0);
    assign res_ready  = (state == S_RUN) && (fifo_count < CNT_W'(DEPTH)) && (acc_cnt < rows_q);
    assign push       = res_valid && res_ready;

    // Write side: show-ahead head entry; empty FIFO presents zero data.
    assign wr_en   = !fifo_empty;
    assign pop     = wr_en && wr_ready;
    assign wr_data = fifo_empty ? '0 : fifo_mem[head];
    assign wr_addr = base_q + 32'(wr_cnt) * 32'(ADDR_STEP);

    assign busy = (state == S_RUN) || (state == S_DRAIN);
    assign done = (state == S_DONE);

    // Row storage is data only; the pointers and count below decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[tail] <= res_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head       <= '0;
            tail       <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            base_q  <= '0;
            rows_q  <= '0;
            acc_cnt <= '0;
            wr_cnt  <= '0;
            err     <= 1'b0;
        end else begin
            if (push) begin
                acc_cnt <= acc_cnt + 16'd1;
            end
            if (pop) begin
                wr_cnt <= wr_cnt + 16'd1;
            end

            // A stray row outside RUN wins over the clear from a same-cycle start.
            if (res_valid && (state != S_RUN)) begin
                err <= 1'b1;
            end else if (start && (state == S_IDLE)) begin
                err <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        base_q  <= base_addr;
                        rows_q  <= row_count;
                        acc_cnt <= '0;
                        wr_cnt  <= '0;
                        state   <= (row_count != 16'd0) ? S_RUN : S_DONE;
                    end
                end
                S_RUN: begin
                    if (push && (acc_cnt == rows_q - 16'd1)) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (pop && (wr_cnt == rows_q - 16'd1)) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        fifo_count <= CNT_W'(DEPTH));

    a_stall_hold: assert property (@(posedge clk) disable iff (rst)
        (wr_en && !wr_ready) |=> (wr_en && $stable(wr_addr) && $stable(wr_data)));

    a_writes_trail_accepts: assert property (@(posedge clk) disable iff (rst)
        wr_cnt <= acc_cnt);
`endif

endmodule
